// File: rtl/udma_qspi_cmd_buffer.sv
// Elastic in-order command FIFO between the uDMA command channel and the QSPI master command input.
// Latency: a word pushed at edge N is presented at the output right after edge N (1 cycle).
// Backpressure: in_ready_o drops when full or during clr/reset; no same-cycle pop lookahead.
// Optional low-watermark refill event: define UDMA_QSPI_CMD_BUF_WM_EN.
module udma_qspi_cmd_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int LW         = $clog2(DEPTH) + 1,
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
`ifdef UDMA_QSPI_CMD_BUF_WM_EN
  input  logic [LW-1:0]         wm_i,
  output logic                  wm_evt_o,
`endif
  output logic [LW-1:0]         level_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full, empty, push, pop;

  // Handshake decode; the level counter is the sole full/empty source.
  always_comb begin
    full        = (level_q == LW'(DEPTH));
    empty       = (level_q == '0);
    in_ready_o  = !full && !rst_i && !clr_i;
    out_valid_o = !empty;
    out_data_o  = mem_q[rptr_q];
    level_o     = level_q;
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
  end

  // Next-state for storage, pointers and level; a flush discards any concurrent pop.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      mem_d[wptr_q] = in_data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  // State registers; reset additionally zeroes the storage array.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

`ifdef UDMA_QSPI_CMD_BUF_WM_EN
  logic wm_evt_q, wm_evt_d;

  // Fire when the level crosses from >= wm to < wm through pops only; a
  // threshold change alone cannot fire since it needs level_d < level_q.
  always_comb begin
    wm_evt_d = (wm_i != '0) && !clr_i && (level_q >= wm_i) && (level_d < wm_i);
    wm_evt_o = wm_evt_q;
  end

  // Registered event so it aligns with the cycle level_o shows the new value.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      wm_evt_q <= 1'b0;
    end else begin
      wm_evt_q <= wm_evt_d;
    end
  end
`endif

endmodule

// File: tb/tb_udma_qspi_cmd_buffer.sv
// Directed self-checking bench for udma_qspi_cmd_buffer (DEPTH=4, DATA_WIDTH=32).
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
// Watermark scenarios are exercised only when UDMA_QSPI_CMD_BUF_WM_EN is defined.
module tb_udma_qspi_cmd_buffer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  level_o;
`ifdef UDMA_QSPI_CMD_BUF_WM_EN
  logic [2:0]  wm_i;
  logic        wm_evt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udma_qspi_cmd_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .sys_clk_i  (clk),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
`ifdef UDMA_QSPI_CMD_BUF_WM_EN
    .wm_i       (wm_i),
    .wm_evt_o   (wm_evt_o),
`endif
    .level_o    (level_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
    tick();
    rst_i = 1'b0;
  endtask

  // Push n words data0, data0+1, ... with the output stalled.
  task automatic fill(input int n, input logic [31:0] data0);
    out_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = data0 + 32'(i);
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clr_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h55; out_ready_i = 1'b0;
`ifdef UDMA_QSPI_CMD_BUF_WM_EN
    wm_i = 3'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++;
      if (in_ready_o !== 1'b0 || level_o !== 3'd0 || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: ready=%b level=%0d valid=%b, want 0 0 0", i, in_ready_o, level_o, out_valid_o);
      end
    end
    rst_i = 1'b0; #1;
    checks++;
    if (in_ready_o !== 1'b1 || out_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: ready=%b data=%h, want 1 0", in_ready_o, out_data_o);
    end
`ifdef UDMA_QSPI_CMD_BUF_WM_EN
    checks++;
    if (wm_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_wm_evt: got %b want 0", wm_evt_o);
    end
`endif
    tick(); #1;
    checks++;
    if (level_o !== 3'd1 || out_valid_o !== 1'b1 || out_data_o !== 32'h55) begin
      errors++;
      $display("FAIL reset_first_push: level=%0d valid=%b data=%h, want 1 1 55", level_o, out_valid_o, out_data_o);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_order_wrap();
    int sent = 0;
    int got  = 0;
    int cnt  = 0;
    int cyc  = 0;
    bit do_push, do_pop;
    do_reset();
    while (got < 10 && cyc < 100) begin
      in_valid_i  = (sent < 10);
      in_data_i   = 32'hA0 + 32'(sent);
      out_ready_i = cyc[0];
      #1;
      checks++;
      if (in_ready_o !== (cnt < 4) || out_valid_o !== (cnt > 0) || level_o !== 3'(cnt)) begin
        errors++;
        $display("FAIL order_flags cyc%0d: ready=%b valid=%b level=%0d, want level %0d", cyc, in_ready_o, out_valid_o, level_o, cnt);
      end
      do_push = (sent < 10) && (cnt < 4);
      do_pop  = cyc[0] && (cnt > 0);
      if (do_pop) begin
        checks++;
        if (out_data_o !== 32'hA0 + 32'(got)) begin
          errors++;
          $display("FAIL order_data #%0d: got %h want %h", got, out_data_o, 32'hA0 + 32'(got));
        end
        got++;
      end
      if (do_push) sent++;
      cnt = cnt + int'(do_push) - int'(do_pop);
      tick();
      cyc++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL order_timeout: popped %0d want 10", got);
    end
  endtask

  task automatic test_full();
    do_reset();
    fill(4, 32'hB0);
    #1;
    checks++;
    if (level_o !== 3'd4 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_state: level=%0d ready=%b, want 4 0", level_o, in_ready_o);
    end
    in_valid_i = 1'b1; in_data_i = 32'hB4; out_ready_i = 1'b1; #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_no_lookahead: ready=%b want 0", in_ready_o);
    end
    tick();
    out_ready_i = 1'b0; #1;
    checks++;
    if (in_ready_o !== 1'b1 || level_o !== 3'd3 || out_data_o !== 32'hB1) begin
      errors++;
      $display("FAIL full_after_pop: ready=%b level=%0d data=%h, want 1 3 b1", in_ready_o, level_o, out_data_o);
    end
    tick();
    in_valid_i = 1'b0; #1;
    checks++;
    if (level_o !== 3'd4) begin
      errors++;
      $display("FAIL full_fifth_push: level=%0d want 4", level_o);
    end
    out_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      checks++;
      if (out_data_o !== 32'hB0 + 32'(i)) begin
        errors++;
        $display("FAIL full_drain #%0d: got %h want %h", i, out_data_o, 32'hB0 + 32'(i));
      end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(2, 32'hC0);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'hC2 + 32'(i); out_ready_i = 1'b1; #1;
      checks++;
      if (level_o !== 3'd2 || out_data_o !== 32'hC0 + 32'(i)) begin
        errors++;
        $display("FAIL b2b cyc%0d: level=%0d data=%h, want 2 %h", i, level_o, out_data_o, 32'hC0 + 32'(i));
      end
      tick();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
    checks++;
    if (level_o !== 3'd2 || out_data_o !== 32'hCA) begin
      errors++;
      $display("FAIL b2b_end: level=%0d data=%h, want 2 ca", level_o, out_data_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill(3, 32'hD0);
    clr_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDF; out_ready_i = 1'b1; #1;
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || level_o !== 3'd3) begin
      errors++;
      $display("FAIL flush_cycle: ready=%b valid=%b level=%0d, want 0 1 3", in_ready_o, out_valid_o, level_o);
    end
    tick();
    clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
    checks++;
    if (level_o !== 3'd0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: level=%0d valid=%b, want 0 0", level_o, out_valid_o);
    end
    in_valid_i = 1'b1; in_data_i = 32'hE0;
    tick();
    in_valid_i = 1'b0; #1;
    checks++;
    if (level_o !== 3'd1 || out_data_o !== 32'hE0) begin
      errors++;
      $display("FAIL flush_refill: level=%0d data=%h, want 1 e0", level_o, out_data_o);
    end
  endtask

`ifdef UDMA_QSPI_CMD_BUF_WM_EN
  // Drain a full buffer one pop per cycle; evt must fire only when level shows exp_lvl.
  task automatic wm_drain(input logic [2:0] thr, input int exp_lvl);
    wm_i = thr;
    do_reset();
    fill(4, 32'hF0);
    out_ready_i = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick(); #1;
      checks++;
      if (wm_evt_o !== (i == exp_lvl) || level_o !== 3'(i)) begin
        errors++;
        $display("FAIL wm_drain thr%0d lvl%0d: evt=%b level=%0d", thr, i, wm_evt_o, level_o);
      end
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_watermark();
    wm_drain(3'd2, 1);
    wm_drain(3'd0, -1);
    wm_i = 3'd2;
    do_reset();
    fill(4, 32'hF0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (wm_evt_o !== 1'b0 || level_o !== 3'd0) begin
        errors++;
        $display("FAIL wm_flush cyc%0d: evt=%b level=%0d, want 0 0", i, wm_evt_o, level_o);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_order_wrap();
    test_full();
    test_back_to_back();
    test_flush();
`ifdef UDMA_QSPI_CMD_BUF_WM_EN
    test_watermark();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
